alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle MIPS-style ALU in the fast-SVD datapath. It executes R-type `funct` operations on WIDTH-bit operands:

- Shift, add/sub, logic and compare operations complete in one cycle.
- MULT/MULTU run as an iterative shift-add multiplier that produces a HI/LO pair.
- Results leave through a registered valid/ready output stage.

The block sits between the operand-fetch stage and the SVD rotation/accumulate units.

---
 rtl/alu_pipe_pkg.sv | 34 +++
 rtl/alu_mul_seq.sv | 57 +++++
 rtl/alu_pipe.sv | 139 +++++++++++++
 tb/tb_alu_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the handshaked MIPS-style ALU: funct codes, FSM states
// and the multiply decode helper.
package alu_pipe_pkg;

  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnSllv  = 6'h04;
  localparam logic [5:0] FnSrlv  = 6'h06;
  localparam logic [5:0] FnSrav  = 6'h07;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnNor   = 6'h27;
  localparam logic [5:0] FnSlt   = 6'h2A;
  localparam logic [5:0] FnSltu  = 6'h2B;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StHold
  } state_e;

  function automatic logic is_mul(input logic [5:0] funct);
    return (funct == FnMult) || (funct == FnMultu);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle on operand magnitudes,
// sign applied to the full product on the final step.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic                busy_q, neg_q;
  logic [CntW-1:0]     cnt_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [2*WIDTH-1:0]  p_q, p_step;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    mag_a, mag_b, addend;

  always_comb begin
    // Negating the most-negative value yields its correct unsigned magnitude.
    mag_a  = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b  = (signed_op && b[WIDTH-1]) ? -b : b;
    addend = p_q[0] ? mcand_q : {WIDTH{1'b0}};
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    p_step = {sum, p_q[WIDTH-1:1]};
    // The last step's product is handed out combinationally so it lands on the same edge.
    done   = busy_q && (cnt_q == CntW'(WIDTH - 1));
    prod   = neg_q ? -p_step : p_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      p_q     <= '0;
    end else if (start) begin
      busy_q  <= 1'b1;
      neg_q   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      cnt_q   <= '0;
      mcand_q <= mag_a;
      p_q     <= {{WIDTH{1'b0}}, mag_b};
    end else if (busy_q) begin
      p_q   <= p_step;
      cnt_q <= cnt_q + CntW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked R-type ALU: single-cycle ops straight into a registered output stage,
// MULT/MULTU through the iterative multiplier with the pipe stalled until consumed.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [5:0]         funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               ovf,
  output logic               illegal
);

  state_e             state_q;
  logic               out_valid_q, ovf_q, illegal_q;
  logic [WIDTH-1:0]   result_q, result_hi_q;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   alu_res, sum, diff;
  logic               alu_ovf, alu_ill;
  logic [SHAMT_W-1:0] sh_var;

  assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul(funct);

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    sum     = a + b;
    diff    = a - b;
    sh_var  = a[SHAMT_W-1:0];
    case (funct)
      FnSll:  alu_res = b << shamt;
      FnSrl:  alu_res = b >> shamt;
      FnSra:  alu_res = $signed(b) >>> shamt;
      FnSllv: alu_res = b << sh_var;
      FnSrlv: alu_res = b >> sh_var;
      FnSrav: alu_res = $signed(b) >>> sh_var;
      FnAdd: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      FnAddu: alu_res = sum;
      FnSub: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      FnSubu: alu_res = diff;
      FnAnd:  alu_res = a & b;
      FnOr:   alu_res = a | b;
      FnXor:  alu_res = a ^ b;
      FnNor:  alu_res = ~(a | b);
      FnSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      FnSltu: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      FnMult, FnMultu: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mul_start),
    .signed_op(funct == FnMult),
    .a        (a),
    .b        (b),
    .done     (mul_done),
    .prod     (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_mul(funct)) begin
              out_valid_q <= 1'b0;
              state_q     <= StMul;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              result_hi_q <= '0;
              ovf_q       <= alu_ovf;
              illegal_q   <= alu_ill;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        StMul: begin
          if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[WIDTH-1:0];
            result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results queued at drive time, popped and
// compared when the output stage presents them.
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ovf;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    exp_t        e;
    int          lat;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, ovf, illegal;
  logic [31:0] a = '0, b = '0, result, result_hi;
  logic [4:0]  shamt = '0;
  logic [5:0]  funct = '0;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
  logic        ovf16, illegal16;
  logic [15:0] a16 = '0, b16 = '0, result16, result_hi16;
  logic [3:0]  shamt16 = '0;
  logic [5:0]  funct16 = '0;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .shamt(shamt), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .ovf(ovf), .illegal(illegal)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16),
    .b(b16), .shamt(shamt16), .funct(funct16), .out_valid(out_valid16),
    .out_ready(out_ready16), .result(result16), .result_hi(result_hi16), .ovf(ovf16),
    .illegal(illegal16)
  );

  function automatic op_t mk(input logic [5:0] f, input logic [31:0] aa, input logic [31:0] bb,
                             input logic [4:0] sh, input logic [31:0] lo, input logic [31:0] hi,
                             input logic ov, input logic il, input int lat);
    op_t o;
    o.f = f; o.a = aa; o.b = bb; o.sh = sh; o.lat = lat;
    o.e.lo = lo; o.e.hi = hi; o.e.ovf = ov; o.e.ill = il;
    return o;
  endfunction

  // Offers one op, then counts negedges from acceptance until out_valid is seen.
  task automatic run_op(input op_t op, output exp_t obs, output int lat);
    int g = 0;
    @(negedge clk);
    funct = op.f; a = op.a; b = op.b; shamt = op.sh; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    while (!in_ready && g < 100) begin @(negedge clk); #1; g++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    obs = '{result, result_hi, ovf, illegal};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({out_valid, result, result_hi, ovf, illegal, in_ready} !== {1'b0, 64'h0, 3'b001}) begin
      n_fail++;
      $display("FAIL reset_hold: got v=%b r=%h hi=%h o=%b i=%b rdy=%b, want 0/0/0/0/0/1",
               out_valid, result, result_hi, ovf, illegal, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, result, result_hi, ovf, illegal, in_ready} !== {1'b0, 64'h0, 3'b001}) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b r=%h rdy=%b, want v=0 r=0 rdy=1",
               out_valid, result, in_ready);
    end
  endtask

  task automatic test_shift();
    op_t  tbl[$];
    exp_t obs, e;
    int   lat;
    tbl.push_back(mk(6'h00, 32'h1000, 32'h4, 5'd1, 32'h8, 0, 0, 0, 1));
    tbl.push_back(mk(6'h02, 32'h1000, 32'h4, 5'd1, 32'h2, 0, 0, 0, 1));
    tbl.push_back(mk(6'h07, 32'h4, 32'h8000_0000, 5'd0, 32'hF800_0000, 0, 0, 0, 1));
    tbl.push_back(mk(6'h03, 32'h0, 32'h8000_0010, 5'd4, 32'hF800_0001, 0, 0, 0, 1));
    tbl.push_back(mk(6'h04, 32'h23, 32'h1, 5'd0, 32'h8, 0, 0, 0, 1));
    tbl.push_back(mk(6'h06, 32'h1F, 32'h8000_0000, 5'd0, 32'h1, 0, 0, 0, 1));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i].e);
      run_op(tbl[i], obs, lat);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e || lat != tbl[i].lat) begin
        n_fail++;
        $display("FAIL shift[%0d] f=%h: got %h lat %0d, want %h lat %0d",
                 i, tbl[i].f, obs, lat, e, tbl[i].lat);
      end
    end
  endtask

  task automatic test_arith();
    op_t  tbl[$];
    exp_t obs, e;
    int   lat;
    tbl.push_back(mk(6'h20, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0, 1, 0, 1));
    tbl.push_back(mk(6'h21, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0, 0, 0, 1));
    tbl.push_back(mk(6'h20, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h22, 32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 0, 1, 0, 1));
    tbl.push_back(mk(6'h23, 32'h5, 32'h7, 0, 32'hFFFF_FFFE, 0, 0, 0, 1));
    tbl.push_back(mk(6'h2A, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 0, 0, 0, 1));
    tbl.push_back(mk(6'h2B, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h27, 32'h0F0F_0F0F, 32'h0, 0, 32'hF0F0_F0F0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h26, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 32'hF0F0_F0F0, 0, 0, 0, 1));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i].e);
      run_op(tbl[i], obs, lat);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e || lat != tbl[i].lat) begin
        n_fail++;
        $display("FAIL arith[%0d] f=%h: got %h lat %0d, want %h lat %0d",
                 i, tbl[i].f, obs, lat, e, tbl[i].lat);
      end
    end
  endtask

  task automatic test_mul();
    op_t  tbl[$];
    exp_t obs, e;
    int   lat;
    tbl.push_back(mk(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h1, 32'hFFFF_FFFE, 0, 0, 33));
    tbl.push_back(mk(6'h18, 32'hFFFF_FFFD, 32'h5, 0, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 0, 0, 33));
    tbl.push_back(mk(6'h18, 32'h8000_0000, 32'h8000_0000, 0, 32'h0, 32'h4000_0000, 0, 0, 33));
    tbl.push_back(mk(6'h19, 32'h1234_5678, 32'h10, 0, 32'h2345_6780, 32'h1, 0, 0, 33));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i].e);
      run_op(tbl[i], obs, lat);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e || lat != tbl[i].lat) begin
        n_fail++;
        $display("FAIL mul[%0d] f=%h: got %h lat %0d, want %h lat %0d",
                 i, tbl[i].f, obs, lat, e, tbl[i].lat);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t obs, e;
    int   lat;
    sb.push_back('{32'h0, 32'h0, 1'b0, 1'b1});
    run_op(mk(6'h3F, 32'h5, 32'h3, 0, 0, 0, 0, 1, 1), obs, lat);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || lat != 1) begin
      n_fail++;
      $display("FAIL illegal: got %h lat %0d, want %h lat 1", obs, lat, e);
    end
  endtask

  task automatic test_back_to_back();
    op_t  tbl[$];
    exp_t obs, e;
    int   g;
    tbl.push_back(mk(6'h20, 32'h1, 32'h2, 0, 32'h3, 0, 0, 0, 1));
    tbl.push_back(mk(6'h22, 32'hA, 32'h3, 0, 32'h7, 0, 0, 0, 1));
    tbl.push_back(mk(6'h25, 32'h100, 32'h1, 0, 32'h101, 0, 0, 0, 1));
    tbl.push_back(mk(6'h2B, 32'h1, 32'h2, 0, 32'h1, 0, 0, 0, 1));
    out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        obs = '{result, result_hi, ovf, illegal};
        n_tests++;
        if (out_valid !== 1'b1 || obs !== e) begin
          n_fail++;
          $display("FAIL stream[%0d]: got v=%b %h, want v=1 %h", i - 1, out_valid, obs, e);
        end
      end
      if (i < 4) begin
        funct = tbl[i].f; a = tbl[i].a; b = tbl[i].b; shamt = tbl[i].sh; in_valid = 1'b1;
        sb.push_back(tbl[i].e);
      end else begin
        in_valid = 1'b0;
      end
    end
    // Multiply, then offer an op in the very cycle its result is consumed.
    @(negedge clk);
    funct = 6'h19; a = 32'h3; b = 32'h4; in_valid = 1'b1;
    sb.push_back('{32'hC, 32'h0, 1'b0, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    funct = 6'h26; a = 32'hF0; b = 32'hFF; in_valid = 1'b1;
    sb.push_back('{32'h0F, 32'h0, 1'b0, 1'b0});
    #1;
    e = sb.pop_front();
    obs = '{result, result_hi, ovf, illegal};
    n_tests++;
    if (out_valid !== 1'b1 || obs !== e || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_rdy: got v=%b %h rdy=%b, want v=1 %h rdy=0", out_valid, obs, in_ready, e);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_bubble: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || result !== e.lo) begin
      n_fail++;
      $display("FAIL after_hold: got v=%b r=%h, want v=1 r=%h", out_valid, result, e.lo);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    @(negedge clk);
    funct = 6'h24; a = 32'hF0F0; b = 32'hFF00; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back('{32'hF000, 32'h0, 1'b0, 1'b0});
    @(negedge clk);
    funct = 6'h25; a = 32'h3; b = 32'hC;
    sb.push_back('{32'hF, 32'h0, 1'b0, 1'b0});
    e = sb[0];
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || result !== e.lo || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%b r=%h rdy=%b, want v=1 r=%h rdy=0",
                 k, out_valid, result, in_ready, e.lo);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    e = sb.pop_front();
    n_tests++;
    if (in_ready !== 1'b1 || result !== e.lo) begin
      n_fail++;
      $display("FAIL release: got rdy=%b r=%h, want rdy=1 r=%h", in_ready, result, e.lo);
    end
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || result !== e.lo) begin
      n_fail++;
      $display("FAIL no_bubble: got v=%b r=%h, want v=1 r=%h", out_valid, result, e.lo);
    end
  endtask

  task automatic test_mul_reset();
    exp_t obs, e;
    int   lat;
    logic seen;
    @(negedge clk);
    funct = 6'h19; a = 32'hFFFF_FFFF; b = 32'h2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if ({out_valid, result, result_hi, ovf, illegal} !== 67'h0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_reset[%0d]: got v=%b r=%h hi=%h o=%b i=%b rdy=%b, want all 0 rdy=1",
                 k, out_valid, result, result_hi, ovf, illegal, in_ready);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got out_valid=1 after reset, want no result");
    end
    sb.push_back('{32'hFF, 32'h0, 1'b0, 1'b0});
    run_op(mk(6'h25, 32'hF0, 32'h0F, 0, 32'hFF, 0, 0, 0, 1), obs, lat);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e || lat != 1) begin
      n_fail++;
      $display("FAIL first_after_reset: got %h lat %0d, want %h lat 1", obs, lat, e);
    end
  endtask

  task automatic test_width16();
    int g = 0;
    int lat;
    @(negedge clk);
    funct16 = 6'h19; a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1; out_ready16 = 1'b1;
    #1;
    while (!in_ready16 && g < 100) begin @(negedge clk); #1; g++; end
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 100) begin @(negedge clk); lat++; end
    n_tests++;
    if (result_hi16 !== 16'hFFFE || result16 !== 16'h0001 || lat != 17) begin
      n_fail++;
      $display("FAIL mul16: got hi=%h lo=%h lat %0d, want hi=fffe lo=0001 lat 17",
               result_hi16, result16, lat);
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_arith();
    test_illegal();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_mul_reset();
    test_width16();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
